// File: rtl/multiplier_exec.sv
`timescale 1ns/1ps
// Radix-2 unsigned shift-add multiplier: 32x32 -> 64 over 32 EXEC cycles,
// with the partial product visible on {U,V} throughout.
module multiplier_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [31:0] multiplier,
  input  logic [31:0] multiplicand,
  output logic [1:0]  state,
  output logic [31:0] U,
  output logic [31:0] V,
  output logic        op_done
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    u_q, u_d;
  logic [W-1:0]    v_q, v_d;
  logic [W-1:0]    m_q, m_d;
  logic [CW-1:0]   count_q, count_d;
  logic            op_done_q;
  logic [W:0]      sum;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      u_q       <= '0;
      v_q       <= '0;
      m_q       <= '0;
      count_q   <= '0;
      op_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      u_q       <= u_d;
      v_q       <= v_d;
      m_q       <= m_d;
      count_q   <= count_d;
      op_done_q <= (state_d == S_DONE);
    end
  end

  // Next-state and datapath step; the 33-bit sum keeps the carry into the shift
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    m_d     = m_q;
    count_d = count_q;
    sum     = {1'b0, u_q} + (v_q[0] ? {1'b0, m_q} : (W+1)'(0));

    if (op_clear) begin
      state_d = S_IDLE;
      u_d     = '0;
      v_d     = '0;
      m_d     = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          u_d     = '0;
          v_d     = '0;
          m_d     = '0;
          count_d = '0;
          if (op_start) begin
            v_d     = multiplier;
            m_d     = multiplicand;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          u_d     = sum[W:1];
          v_d     = {sum[0], v_q[W-1:1]};
          count_d = count_q + CW'(1);
          if (count_q == CW'(W - 1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          u_d     = '0;
          v_d     = '0;
          m_d     = '0;
          count_d = '0;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign U       = u_q;
  assign V       = v_q;
  assign op_done = op_done_q;

endmodule
